// File: rtl/cpu_input_conditioner_pkg.sv
// Shared CPU front-end constants: data width, clock rate and default debounce/repeat timing.
// Also used by the control FSM so the board timing lives in one place.
package cpu_input_conditioner_pkg;

   localparam int CPU_DATA_W = 4;
   localparam int CLK_HZ     = 50000000;

   // 10 ms debounce, 0.5 s to first repeat, 0.1 s between repeats
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
   localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;
   localparam int DEF_REPEAT_PERIOD   = CLK_HZ / 10;

   typedef logic [CPU_DATA_W-1:0] sw_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cpu_debounce_bit.sv
// One raw input: SYNC_STAGES flop synchroniser, then a level must differ from the stable value
// for DEBOUNCE_CYCLES consecutive cycles before it is accepted. o_accept is high on the accepting edge.
module cpu_debounce_bit #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_stable,
   output logic o_accept
);

   localparam int             CW     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  C_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_stable;
   logic [CW-1:0]          r_cnt;
   logic                   w_sync;
   logic                   w_diff;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_diff   = w_sync ^ r_stable;
   assign o_accept = w_diff && (r_cnt == C_LAST);
   assign o_stable = r_stable;

   // Any bounce back to the stable level restarts the count from zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync   <= {SYNC_STAGES{RESET_VAL}};
         r_stable <= RESET_VAL;
         r_cnt    <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (o_accept) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + C_ONE;
         end
      end
   end

endmodule

// File: rtl/cpu_input_conditioner.sv
// Debounces SW[3:0] and the active-low step key for the 4-bit CPU; produces change/step strobes.
// Optional auto-repeat of step_pulse while the key is held: define CPU_INPUT_AUTOREPEAT_EN.
module cpu_input_conditioner
   import cpu_input_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                  CLK50,
   input  logic                  RESET,
   input  logic [CPU_DATA_W-1:0] SW_RAW,
   input  logic                  KEY_STEP_N,
   output logic [CPU_DATA_W-1:0] sw_clean,
   output logic                  sw_changed,
   output logic                  step_level,
   output logic                  step_pulse
);

   sw_t  w_sw_stable;
   sw_t  w_sw_accept;
   logic w_key_stable;
   logic w_key_accept;
   logic w_press;
   logic w_pulse_next;
   logic r_sw_changed;
   logic r_step_pulse;

   for (genvar g = 0; g < CPU_DATA_W; g++) begin : g_sw
      cpu_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_sw (
         .i_clk    (CLK50),
         .i_rst    (RESET),
         .i_raw    (SW_RAW[g]),
         .o_stable (w_sw_stable[g]),
         .o_accept (w_sw_accept[g])
      );
   end

   cpu_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_key (
      .i_clk    (CLK50),
      .i_rst    (RESET),
      .i_raw    (KEY_STEP_N),
      .o_stable (w_key_stable),
      .o_accept (w_key_accept)
   );

   // Accepting while still released means the key is going down.
   assign w_press = w_key_accept & w_key_stable;

`ifdef CPU_INPUT_AUTOREPEAT_EN
   localparam int            RW      = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [RW-1:0] C_DELAY = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] C_PER   = RW'(REPEAT_PERIOD - 1);
   localparam logic [RW-1:0] C_RONE  = RW'(1);

   logic [RW-1:0] r_rep_cnt;
   logic          r_rep_armed;
   logic          w_rep_fire;

   assign w_rep_fire = step_level && !w_key_accept &&
                       (r_rep_cnt == (r_rep_armed ? C_PER : C_DELAY));

   always_ff @(posedge CLK50) begin
      if (RESET || !step_level || w_key_accept) begin
         r_rep_cnt   <= '0;
         r_rep_armed <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep_cnt   <= '0;
         r_rep_armed <= 1'b1;
      end else begin
         r_rep_cnt <= r_rep_cnt + C_RONE;
      end
   end

   assign w_pulse_next = w_press | w_rep_fire;
`else
   assign w_pulse_next = w_press;
`endif

   always_ff @(posedge CLK50) begin
      if (RESET) begin
         r_sw_changed <= 1'b0;
         r_step_pulse <= 1'b0;
      end else begin
         r_sw_changed <= |w_sw_accept;
         r_step_pulse <= w_pulse_next;
      end
   end

   assign sw_clean   = w_sw_stable;
   assign sw_changed = r_sw_changed;
   assign step_level = ~w_key_stable;
   assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_cpu_input_conditioner.sv
// Directed bench for cpu_input_conditioner with short debounce/repeat timing.
module tb_cpu_input_conditioner;

   logic       CLK50 = 1'b0;
   logic       RESET;
   logic [3:0] SW_RAW;
   logic       KEY_STEP_N;
   logic [3:0] sw_clean;
   logic       sw_changed;
   logic       step_level;
   logic       step_pulse;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_chg    = 0;
   int n_step   = 0;
   int base_chg;
   int base_step;
   int step_t[$];

   cpu_input_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (6)
   ) dut (
      .CLK50      (CLK50),
      .RESET      (RESET),
      .SW_RAW     (SW_RAW),
      .KEY_STEP_N (KEY_STEP_N),
      .sw_clean   (sw_clean),
      .sw_changed (sw_changed),
      .step_level (step_level),
      .step_pulse (step_pulse)
   );

   always #5 CLK50 = ~CLK50;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK50);
         #1;
         cyc++;
         if (sw_changed) n_chg++;
         if (step_pulse) begin
            n_step++;
            step_t.push_back(cyc);
         end
      end
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      int t0;
      int exp_t[$];

      // 1: switches high through reset
      RESET = 1'b1; SW_RAW = 4'hA; KEY_STEP_N = 1'b1;
      tick(3);
      check("rst_sw_clean", sw_clean, 0);
      check("rst_sw_changed", sw_changed, 0);
      check("rst_step_level", step_level, 0);
      check("rst_step_pulse", step_pulse, 0);
      RESET = 1'b0;
      base_chg = n_chg;
      tick(9);
      check("t1_clean_hold", sw_clean, 0);
      check("t1_no_early_chg", n_chg - base_chg, 0);
      tick(1);
      check("t1_clean_at10", sw_clean, 'hA);
      check("t1_chg_at10", sw_changed, 1);
      tick(1);
      check("t1_chg_single", sw_changed, 0);

      // 2: clean 0 -> 5 transition (two bits falling together give one strobe)
      SW_RAW = 4'h0;
      base_chg = n_chg;
      tick(15);
      check("t2_clear", sw_clean, 0);
      check("t2_clear_one_chg", n_chg - base_chg, 1);
      SW_RAW = 4'h5;
      base_chg = n_chg;
      tick(9);
      check("t2_hold", sw_clean, 0);
      tick(1);
      check("t2_clean_at10", sw_clean, 5);
      check("t2_chg_at10", sw_changed, 1);
      tick(5);
      check("t2_one_chg", n_chg - base_chg, 1);

      // 3: bit0 bouncing every 3 cycles never gets through
      SW_RAW = 4'h4;
      tick(15);
      check("t3_start", sw_clean, 4);
      base_chg = n_chg;
      for (int i = 0; i < 12; i++) begin
         SW_RAW[0] = ~SW_RAW[0];
         tick(3);
      end
      check("t3_bounce_clean", sw_clean, 4);
      check("t3_bounce_no_chg", n_chg - base_chg, 0);
      SW_RAW[0] = 1'b1;
      tick(9);
      check("t3_final_hold", sw_clean, 4);
      tick(1);
      check("t3_final_at10", sw_clean, 5);
      check("t3_final_one_chg", n_chg - base_chg, 1);

      // 4: bouncy press, hold, release
      base_step = n_step;
      for (int i = 0; i < 4; i++) begin
         KEY_STEP_N = 1'b0; tick(2);
         KEY_STEP_N = 1'b1; tick(2);
      end
      check("t4_bounce_level", step_level, 0);
      check("t4_bounce_no_pulse", n_step - base_step, 0);
      KEY_STEP_N = 1'b0;
      tick(9);
      check("t4_press_hold", step_level, 0);
      tick(1);
      check("t4_level_at10", step_level, 1);
      check("t4_pulse_at10", step_pulse, 1);
      tick(20);
      KEY_STEP_N = 1'b1;
      tick(15);
      check("t4_released", step_level, 0);
`ifdef CPU_INPUT_AUTOREPEAT_EN
      check("t4_pulses", n_step - base_step, 3);
`else
      check("t4_pulses", n_step - base_step, 1);
`endif

      // 5: reset aborts a debounce in progress
      SW_RAW = 4'hF;
      base_chg = n_chg;
      tick(5);
      RESET = 1'b1;
      SW_RAW = 4'h0;
      tick(1);
      check("t5_rst_clean", sw_clean, 0);
      check("t5_rst_chg", sw_changed, 0);
      tick(2);
      RESET = 1'b0;
      tick(20);
      check("t5_after_clean", sw_clean, 0);
      check("t5_no_chg", n_chg - base_chg, 0);
      check("t5_step_level", step_level, 0);

      // 6: long hold, pulse timing
      step_t.delete();
      KEY_STEP_N = 1'b0;
      t0 = cyc + 10;
      tick(60);
      KEY_STEP_N = 1'b1;
      tick(20);
      exp_t.push_back(t0);
`ifdef CPU_INPUT_AUTOREPEAT_EN
      for (int k = 0; k < 7; k++) exp_t.push_back(t0 + 20 + 6 * k);
`endif
      check("t6_pulse_count", step_t.size(), exp_t.size());
      for (int k = 0; k < exp_t.size() && k < step_t.size(); k++)
         check($sformatf("t6_pulse_time%0d", k), step_t[k], exp_t[k]);
      check("t6_released", step_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
